// File: rtl/selten_pkg.sv
// Shared definitions for the DMEM arbiter: default geometry, FSM encoding,
// port index constants and a saturating counter helper.
package selten_pkg;

    localparam int DW_DEF    = 19;
    localparam int AW_DEF    = 5;
    localparam int DEPTH_DEF = 32;

    localparam int P_CORE = 0;
    localparam int P_DBG  = 1;

    typedef enum logic {
        NORM   = 1'b0,
        FORCE1 = 1'b1
    } arb_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/selten_dmem_sp.sv
// Single-port synchronous data memory: one write or one registered read per
// cycle, selected by the arbiter.
module selten_dmem_sp
    import selten_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: the array and its read register take no reset, so synthesis can
    // map them onto plain RAM; output cleanliness after reset is handled by
    // the arbiter's rvalid/hold logic.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/selten_dmem_arbiter.sv
// Two-port arbiter in front of the DMEM: core port has fixed priority, a
// starvation counter forces the loader/debug port through. Optional
// grant/starvation statistics are enabled with SELTEN_ARB_PERF_EN.
module selten_dmem_arbiter
    import selten_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int AW         = AW_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          busy
`ifdef SELTEN_ARB_PERF_EN
    ,
    output logic [15:0]   p0_gnt_cnt,
    output logic [15:0]   p1_gnt_cnt,
    output logic [15:0]   starve_cnt
`endif
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    logic [3:0]    wait_q, wait_d, wait_inc;
    logic [1:0]    gnt;
    logic          p1_lost;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_q;
    logic [DW-1:0] p0_hold, p1_hold;

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q <= NORM;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // NOTE: combinational blocks assign a default first with blocking '=',
    // so no path leaves an output unassigned and no latch is inferred.
    always_comb begin
        p1_lost  = p1_req & ~gnt[P_DBG];
        wait_inc = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
        wait_d   = p1_lost ? wait_inc : 4'd0;
        state_d  = state_q;
        case (state_q)
            NORM:    if (p1_lost && wait_inc >= STARVE_LIM) state_d = FORCE1;
            FORCE1:  state_d = NORM;
            default: state_d = NORM;
        endcase
    end

    // FORCE1 lasts exactly one cycle: either port 1 takes it or, having
    // withdrawn, leaves the slot to the core.
    always_comb begin
        gnt = 2'b00;
        case (state_q)
            NORM: begin
                gnt[P_CORE] = p0_req;
                gnt[P_DBG]  = p1_req & ~p0_req;
            end
            FORCE1: begin
                gnt[P_DBG]  = p1_req;
                gnt[P_CORE] = p0_req & ~p1_req;
            end
            default: gnt = 2'b00;
        endcase
    end

    assign p0_gnt = gnt[P_CORE];
    assign p1_gnt = gnt[P_DBG];

    assign mem_addr  = gnt[P_DBG] ? p1_addr  : p0_addr;
    assign mem_wdata = gnt[P_DBG] ? p1_wdata : p0_wdata;
    assign mem_we    = (gnt[P_CORE] & p0_we)  | (gnt[P_DBG] & p1_we);
    assign mem_re    = (gnt[P_CORE] & ~p0_we) | (gnt[P_DBG] & ~p1_we);

    selten_dmem_sp #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_q)
    );

    // The shared read register is steered to the port that issued the read;
    // each port keeps its own copy so rdata holds until its next read.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_hold   <= '0;
            p1_hold   <= '0;
            busy      <= 1'b0;
        end else begin
            p0_rvalid <= gnt[P_CORE] & ~p0_we;
            p1_rvalid <= gnt[P_DBG] & ~p1_we;
            if (p0_rvalid) p0_hold <= mem_q;
            if (p1_rvalid) p1_hold <= mem_q;
            busy      <= |gnt;
        end
    end

    assign p0_rdata = p0_rvalid ? mem_q : p0_hold;
    assign p1_rdata = p1_rvalid ? mem_q : p1_hold;

`ifdef SELTEN_ARB_PERF_EN
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            p0_gnt_cnt <= 16'd0;
            p1_gnt_cnt <= 16'd0;
            starve_cnt <= 16'd0;
        end else begin
            if (gnt[P_CORE]) p0_gnt_cnt <= sat_inc16(p0_gnt_cnt);
            if (gnt[P_DBG])  p1_gnt_cnt <= sat_inc16(p1_gnt_cnt);
            if (state_q == NORM && state_d == FORCE1) starve_cnt <= sat_inc16(starve_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_selten_dmem_arbiter.sv
// Directed bench for selten_dmem_arbiter: grants checked per cycle, read data
// checked by a scoreboard monitor against hand-computed expectations.
module tb_selten_dmem_arbiter;
    import selten_pkg::*;

    logic        clk = 1'b0;
    logic        RN;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [4:0]  p0_addr, p1_addr;
    logic [18:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, busy;
    logic [18:0] p0_rdata, p1_rdata;
`ifdef SELTEN_ARB_PERF_EN
    logic [15:0] p0_gnt_cnt, p1_gnt_cnt, starve_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_p0_gnts = 0;
    int exp_p1_gnts = 0;
    int exp_starves = 0;
    logic [18:0] q0[$];
    logic [18:0] q1[$];

    always #5 clk = ~clk;

    selten_dmem_arbiter dut (
        .clk       (clk),
        .RN        (RN),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .busy      (busy)
`ifdef SELTEN_ARB_PERF_EN
        ,
        .p0_gnt_cnt(p0_gnt_cnt),
        .p1_gnt_cnt(p1_gnt_cnt),
        .starve_cnt(starve_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read-data monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (p0_rvalid === 1'b1) begin
            if (q0.size() == 0) check("p0_unexpected_rvalid", 32'(p0_rvalid), 32'd0);
            else check("p0_rdata", 32'(p0_rdata), 32'(q0.pop_front()));
        end
        if (p1_rvalid === 1'b1) begin
            if (q1.size() == 0) check("p1_unexpected_rvalid", 32'(p1_rvalid), 32'd0);
            else check("p1_rdata", 32'(p1_rdata), 32'(q1.pop_front()));
        end
    end

    // Called at posedge+1; applies one cycle of requests, checks grants at the
    // negedge and queues the hand-computed read data for a granted read.
    task automatic drive(input logic r0, input logic w0, input logic [4:0] a0, input logic [18:0] d0,
                         input logic r1, input logic w1, input logic [4:0] a1, input logic [18:0] d1,
                         input logic e0, input logic e1, input logic [18:0] x, input string tag);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        @(negedge clk);
        check({tag, "_p0_gnt"}, 32'(p0_gnt), 32'(e0));
        check({tag, "_p1_gnt"}, 32'(p1_gnt), 32'(e1));
        if (e0 && !w0) q0.push_back(x);
        if (e1 && !w1) q1.push_back(x);
        @(posedge clk);
        #1;
        if (e0) exp_p0_gnts++;
        if (e1) exp_p1_gnts++;
    endtask

    task automatic idle(input string tag);
        drive(0, 0, 5'd0, 19'd0, 0, 0, 5'd0, 19'd0, 0, 0, 19'd0, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RN = 1'b0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p0_rvalid", 32'(p0_rvalid), 0);
        check("rst_p1_rvalid", 32'(p1_rvalid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_p0_rdata", 32'(p0_rdata), 0);
        check("rst_p1_rdata", 32'(p1_rdata), 0);
        check("rst_state", 32'(dut.state_q), 32'(NORM));
        check("rst_wait", 32'(dut.wait_q), 0);
        RN = 1'b1;

        // Loader preload, then core reads it back.
        drive(0, 0, 5'd0, 19'd0, 1, 1, 5'd5, 19'h1234A, 0, 1, 19'd0, "p1_wr5");
        check("busy_after_gnt", 32'(busy), 1);
        drive(0, 0, 5'd0, 19'd0, 1, 1, 5'd0, 19'h00ABC, 0, 1, 19'd0, "p1_wr0");
        drive(1, 0, 5'd5, 19'd0, 0, 0, 5'd0, 19'd0, 1, 0, 19'h1234A, "p0_rd5");

        // Top address write then immediate read; address 0 untouched.
        drive(1, 1, 5'd31, 19'h7FFFF, 0, 0, 5'd0, 19'd0, 1, 0, 19'd0, "p0_wr31");
        drive(1, 0, 5'd31, 19'd0, 0, 0, 5'd0, 19'd0, 1, 0, 19'h7FFFF, "p0_rd31");
        drive(1, 0, 5'd0, 19'd0, 0, 0, 5'd0, 19'd0, 1, 0, 19'h00ABC, "p0_rd0");
        idle("idle0");
        check("busy_idle", 32'(busy), 0);
        check("p0_rdata_hold", 32'(p0_rdata), 32'h00ABC);

        // Reset while a p0 read response is pending.
        p0_req = 1; p0_we = 0; p0_addr = 5'd31;
        @(negedge clk);
        check("pre_rst_p0_gnt", 32'(p0_gnt), 1);
        @(posedge clk);
        #1;
        RN = 1'b0;
        p0_req = 0;
        #1;
        check("midrst_p0_rvalid", 32'(p0_rvalid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_state", 32'(dut.state_q), 32'(NORM));
        exp_p0_gnts = 0; exp_p1_gnts = 0; exp_starves = 0;
        @(posedge clk);
        #1;
        RN = 1'b1;
        drive(0, 0, 5'd0, 19'd0, 1, 0, 5'd31, 19'd0, 0, 1, 19'h7FFFF, "p1_rd31_after_rst");

        // Starvation: core busy every cycle, loader forced through on cycle 5.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 5'd10, 19'h2AAAA, (i < 5), 0, 5'd5, 19'd0,
                  (i != 4), (i == 4), 19'h1234A, $sformatf("starve_c%0d", i));
            if (i == 3) begin
                check("starve_state_force1", 32'(dut.state_q), 32'(FORCE1));
                exp_starves++;
            end
        end

        // Loader withdraws while FORCE1: core takes the slot, FSM back to NORM.
        for (int i = 0; i < 4; i++)
            drive(1, 1, 5'd11, 19'h15555, 1, 1, 5'd12, 19'h0F0F0, 1, 0, 19'd0,
                  $sformatf("wd_c%0d", i));
        check("wd_state_force1", 32'(dut.state_q), 32'(FORCE1));
        exp_starves++;
        drive(1, 1, 5'd11, 19'h15555, 0, 0, 5'd12, 19'd0, 1, 0, 19'd0, "wd_withdraw");
        check("wd_state_norm", 32'(dut.state_q), 32'(NORM));
        check("wd_wait_clr", 32'(dut.wait_q), 0);

        drive(1, 0, 5'd10, 19'd0, 0, 0, 5'd0, 19'd0, 1, 0, 19'h2AAAA, "p0_rd10");
        drive(1, 0, 5'd11, 19'd0, 0, 0, 5'd0, 19'd0, 1, 0, 19'h15555, "p0_rd11");
        idle("idle1");
        idle("idle2");

`ifdef SELTEN_ARB_PERF_EN
        check("perf_p0_gnt_cnt", 32'(p0_gnt_cnt), 32'(exp_p0_gnts));
        check("perf_p1_gnt_cnt", 32'(p1_gnt_cnt), 32'(exp_p1_gnts));
        check("perf_starve_cnt", 32'(starve_cnt), 32'(exp_starves));
`endif
        check("p0_reads_returned", 32'(q0.size()), 0);
        check("p1_reads_returned", 32'(q1.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
